// File: rtl/jx2_mem_line_resp.sv
// Jx2 128-bit memory line bus responder: window decode, wait states, OK/FAULT
// status, backed by an internal line RAM split into 32-bit lanes.

module jx2_mem_lane #(
  parameter int ADDR_BITS = 10,
  parameter int VEC_W     = 32
) (
  input  logic                 clock,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] idx,
  input  logic [VEC_W-1:0]     wr_data,
  output logic [VEC_W-1:0]     rd_data
);
  logic [VEC_W-1:0] mem [2**ADDR_BITS];

  always_ff @(posedge clock)
    if (we) mem[idx] <= wr_data;

  // Registered by the responder into memOutData, giving a synchronous read.
  assign rd_data = mem[idx];
endmodule

module jx2_mem_line_resp #(
  parameter int          ADDR_BITS = 10,
  parameter logic [31:0] BASE      = 32'h0000_0000,
  parameter int          LATENCY   = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [127:0] memInData,
  output logic [127:0] memOutData,
  input  logic [31:0]  memAddr,
  input  logic [4:0]   memOpm,
  output logic [1:0]   memOK,
  output logic [7:0]   faultCnt
);
  localparam int HI        = ADDR_BITS + 4;
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 32;

  localparam logic [1:0] OK_READY = 2'd0;
  localparam logic [1:0] OK_OK    = 2'd1;
  localparam logic [1:0] OK_HOLD  = 2'd2;
  localparam logic [1:0] OK_FAULT = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_FLT} state_t;

  state_t                           state_q, state_d;
  logic [3:0]                       cnt_q, cnt_d;
  logic [1:0]                       ok_d;
  logic                             sel, bad, accept, fire, flt_enter, we;
  logic                             store_q;
  logic [ADDR_BITS-1:0]             idx_q;
  logic [NUM_LANES-1:0][VEC_W-1:0]  data_q;
  logic [NUM_LANES-1:0][VEC_W-1:0]  rd_lane;

  assign sel = (memOpm != 5'h00) && (memAddr[31:HI] == BASE[31:HI]);
  assign bad = (memAddr[3:0] != 4'h0) || (memOpm[2:0] != 3'b111) ||
               (memOpm[4:3] == 2'b00) || (memOpm[4:3] == 2'b11);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;
    fire      = 1'b0;
    flt_enter = 1'b0;
    case (state_q)
      S_IDLE:
        if (sel) begin
          if (bad) begin
            state_d   = S_FLT;
            flt_enter = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(LATENCY);
            accept  = 1'b1;
          end
        end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        // An abort wins over completion so a dropped store never commits.
        if (memOpm == 5'h00) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd1) begin
          state_d = S_DONE;
          fire    = 1'b1;
        end
      end
      S_DONE, S_FLT:
        if (memOpm == 5'h00) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_WAIT:  ok_d = OK_HOLD;
      S_DONE:  ok_d = OK_OK;
      S_FLT:   ok_d = OK_FAULT;
      default: ok_d = OK_READY;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      memOK      <= OK_READY;
      memOutData <= '0;
      faultCnt   <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      memOK   <= ok_d;
      if (fire && !store_q) memOutData <= rd_lane;
      if (flt_enter && faultCnt != 8'hFF) faultCnt <= faultCnt + 8'h01;
    end
  end

  // Request capture; contents only matter while a transaction is in flight.
  always_ff @(posedge clock)
    if (accept) begin
      store_q <= memOpm[4];
      idx_q   <= memAddr[HI-1:4];
      data_q  <= memInData;
    end

  assign we = fire && store_q;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    jx2_mem_lane #(.ADDR_BITS(ADDR_BITS), .VEC_W(VEC_W)) u_lane (
      .clock   (clock),
      .we      (we),
      .idx     (idx_q),
      .wr_data (data_q[g]),
      .rd_data (rd_lane[g])
    );
  end
endmodule

// File: tb/tb_jx2_mem_line_resp.sv
// Bench for jx2_mem_line_resp: directed vector table, hand-written abort/reset
// sequences, random transactions against a transaction-level model.

module tb_jx2_mem_line_resp;
  localparam int          LAT  = 2;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [127:0] memInData = '0;
  logic [127:0] memOutData;
  logic [31:0]  memAddr = '0;
  logic [4:0]   memOpm = '0;
  logic [1:0]   memOK;
  logic [7:0]   faultCnt;

  jx2_mem_line_resp #(.ADDR_BITS(10), .BASE(BASE), .LATENCY(LAT)) dut (
    .clock      (clock),
    .reset      (reset),
    .memInData  (memInData),
    .memOutData (memOutData),
    .memAddr    (memAddr),
    .memOpm     (memOpm),
    .memOK      (memOK),
    .faultCnt   (faultCnt)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Model: line contents by index, last load data, fault counter.
  logic [127:0] mdl_mem [int];
  logic [127:0] out_m;
  bit           out_known;
  int           fcnt_m;

  typedef struct {
    logic [4:0]   opm;
    logic [31:0]  addr;
    logic [127:0] data;
    bit           scr;
    int           kind;   // 0 no response, 1 OK, 3 FAULT
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic int kind_of(logic [4:0] opm, logic [31:0] addr);
    if (opm == 5'h00 || (addr >> 14) != (BASE >> 14)) return 0;
    if (addr % 16 != 0 || opm % 8 != 7 || opm / 8 == 0 || opm / 8 == 3) return 3;
    return 1;
  endfunction

  task automatic txn(input logic [4:0] opm, input logic [31:0] addr,
                     input logic [127:0] data, input bit scr, input int kind);
    int idx;
    idx = int'((addr >> 4) % 1024);
    memOpm = opm; memAddr = addr; memInData = data;
    step();
    if (kind == 0) begin
      for (int c = 0; c < 20; c++) begin
        chk("unsel_ok", memOK, 2'd0);
        step();
      end
      chk("unsel_fcnt", faultCnt, fcnt_m);
    end else if (kind == 3) begin
      if (fcnt_m < 255) fcnt_m++;
      chk("fault_ok", memOK, 2'd3);
      chk("fault_cnt", faultCnt, fcnt_m);
      step();
      chk("fault_hold", memOK, 2'd3);
    end else begin
      for (int c = 0; c < LAT; c++) begin
        if (c > 0) step();
        chk("wait_hold", memOK, 2'd2);
        if (scr) begin
          memAddr = addr ^ 32'h10;
          memInData = ~data;
        end
      end
      step();
      chk("done_ok", memOK, 2'd1);
      if (opm / 8 == 1) begin
        out_known = mdl_mem.exists(idx);
        if (out_known) out_m = mdl_mem[idx];
      end else begin
        mdl_mem[idx] = data;
      end
      if (out_known) chk("done_data", memOutData, out_m);
      step();
      chk("done_stay", memOK, 2'd1);
    end
    memOpm = 5'h00;
    memAddr = $urandom;
    step();
    chk("release_ok", memOK, 2'd0);
    if (out_known) chk("release_data", memOutData, out_m);
  endtask

  localparam logic [127:0] D0 = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
  localparam logic [127:0] D1 = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
  localparam logic [127:0] D2 = 128'hA5A5_5A5A_F00D_CAFE_1234_5678_9ABC_DEF0;

  initial begin
    logic [4:0]   opm;
    logic [31:0]  addr;
    logic [127:0] data;
    int           r;

    out_m = '0; out_known = 1'b1; fcnt_m = 0;

    tbl.push_back('{5'h17, 32'h1000_0040, D0, 1'b0, 1});  // store then load
    tbl.push_back('{5'h0F, 32'h1000_0040, '0, 1'b0, 1});
    tbl.push_back('{5'h0F, 32'h1000_0044, '0, 1'b0, 3});  // misaligned
    tbl.push_back('{5'h0F, 32'h1000_0040, '0, 1'b0, 1});  // RAM untouched
    tbl.push_back('{5'h0F, 32'h0000_0040, '0, 1'b0, 0});  // outside window
    tbl.push_back('{5'h0F, 32'h1000_4000, '0, 1'b0, 0});  // just past window
    tbl.push_back('{5'h0E, 32'h1000_0040, '0, 1'b0, 3});  // short size
    tbl.push_back('{5'h1F, 32'h1000_0040, '0, 1'b0, 3});  // reserved op
    tbl.push_back('{5'h07, 32'h1000_0040, '0, 1'b0, 3});  // op field 00
    tbl.push_back('{5'h17, 32'h1000_3FF0, D2, 1'b0, 1});  // last line
    tbl.push_back('{5'h0F, 32'h1000_3FF0, '0, 1'b0, 1});
    tbl.push_back('{5'h17, 32'h1000_0090, D2, 1'b0, 1});
    tbl.push_back('{5'h17, 32'h1000_0080, D1, 1'b1, 1});  // inputs change in WAIT
    tbl.push_back('{5'h0F, 32'h1000_0080, '0, 1'b1, 1});
    tbl.push_back('{5'h0F, 32'h1000_0090, '0, 1'b0, 1});

    step(); step();
    chk("rst_ok", memOK, 2'd0);
    chk("rst_data", memOutData, '0);
    chk("rst_fcnt", faultCnt, 8'h00);
    reset = 1'b0;
    step();

    for (int i = 0; i < tbl.size(); i++)
      txn(tbl[i].opm, tbl[i].addr, tbl[i].data, tbl[i].scr, tbl[i].kind);

    // Abort a store in its first WAIT cycle; line 0x80 must keep D1.
    memOpm = 5'h17; memAddr = 32'h1000_0080; memInData = D0;
    step();
    chk("abort_hold", memOK, 2'd2);
    memOpm = 5'h00;
    step();
    chk("abort_ok", memOK, 2'd0);
    step();
    txn(5'h0F, 32'h1000_0080, '0, 1'b0, 1);

    // Async reset during WAIT of a store.
    memOpm = 5'h17; memAddr = 32'h1000_0080; memInData = D2;
    step();
    chk("arst_hold", memOK, 2'd2);
    #2 reset = 1'b1;
    #1;
    chk("arst_ok", memOK, 2'd0);
    chk("arst_data", memOutData, '0);
    chk("arst_fcnt", faultCnt, 8'h00);
    memOpm = 5'h00;
    out_m = '0; out_known = 1'b1; fcnt_m = 0;
    step();
    reset = 1'b0;
    step();
    txn(5'h0F, 32'h1000_0080, '0, 1'b0, 1);

    for (int i = 0; i < 16; i++)
      txn(5'h17, BASE + 32'(i * 16), {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1);

    for (int i = 0; i < 120; i++) begin
      r = int'($urandom_range(0, 9));
      case (r)
        0, 1, 2: opm = 5'h0F;
        3, 4:    opm = 5'h17;
        5:       opm = {2'b01, 3'($urandom_range(0, 6))};
        6:       opm = {2'b11, 3'($urandom)};
        7:       opm = {2'b00, 3'($urandom)};
        default: opm = {2'($urandom_range(1, 2)), 3'b111};
      endcase
      addr = BASE + 32'($urandom_range(0, 15) * 16);
      r = int'($urandom_range(0, 9));
      if (r == 0) addr = addr + 32'($urandom_range(1, 15));
      else if (r == 1) addr = addr ^ 32'h2000_0000;
      data = {$urandom, $urandom, $urandom, $urandom};
      txn(opm, addr, data, 1'($urandom), kind_of(opm, addr));
    end

    for (int i = 0; i < 300; i++)
      txn(5'h0F, 32'h1000_0044, '0, 1'b0, 3);
    chk("sat_fcnt", faultCnt, 8'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
